if_stage: RTL and testbench

Instruction-fetch stage of the pipelined CPU. It owns the PC register, drives the synchronous instruction memory, and produces the IF/ID pipeline register consumed by decode. The hazard unit controls it through stall and flush inputs, and execute redirects it on taken jumps and branches. It guarantees that the PC and instruction in IF/ID always belong together across stalls, flushes, redirects and reset.

---
 rtl/cpu_pkg.sv | 26 ++
 rtl/if_perf_cnt.sv | 41 ++++
 rtl/if_stage.sv | 131 +++++++++++++
 tb/tb_if_stage.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// ============================================================================
// Module   : cpu_pkg
// Brief    : Shared CPU types: fetch state, IF/ID register layout, NOP word.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

    localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0013;

    typedef enum logic [0:0] {
        BOOT = 1'b0,
        RUN  = 1'b1
    } fetch_state_e;

    // IF/ID pipeline register, also consumed by the decode stage
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] inst;
    } if_id_t;

endpackage

`default_nettype wire

// File: rtl/if_perf_cnt.sv
// ============================================================================
// Module   : if_perf_cnt
// Brief    : Fetch-stage performance counters (fetches, stalls, flushes).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_perf_cnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_ev_i,
    input  logic        stall_ev_i,
    input  logic        flush_ev_i,
    output logic [31:0] fetch_cnt_o,
    output logic [31:0] stall_cnt_o,
    output logic [31:0] flush_cnt_o
);

    logic [31:0] fetch_cnt_q;
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_cnt_q <= 32'h0;
            stall_cnt_q <= 32'h0;
            flush_cnt_q <= 32'h0;
        end else begin
            if (fetch_ev_i) fetch_cnt_q <= fetch_cnt_q + 32'd1;
            if (stall_ev_i) stall_cnt_q <= stall_cnt_q + 32'd1;
            if (flush_ev_i) flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign fetch_cnt_o = fetch_cnt_q;
    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;

endmodule

`default_nettype wire

// File: rtl/if_stage.sv
// ============================================================================
// Module   : if_stage
// Brief    : Instruction fetch: PC register, imem drive and IF/ID register.
//            Optional counters enabled by defining FETCH_PERF_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_stage
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pc_stall,
    input  logic        id_flush,
    input  logic        redirect_en,
    input  logic [31:0] redirect_pc,
    output logic        imem_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        if_id_valid,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_inst,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_flush_cnt
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    if_id_t       if_id_q, if_id_d;
    logic [31:0]  redir_pc_aligned;

    assign redir_pc_aligned = redirect_pc & ~32'h3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= BOOT;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            BOOT:    state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // A redirect or flush makes pc_q's instruction wrong-path, so IF/ID
    // takes a bubble tagged with pc_q instead of the memory data.
    always_comb begin
        pc_d          = pc_q + 32'd4;
        imem_en       = 1'b1;
        if_id_d       = if_id_q;
        case (state_q)
            RUN: begin
                if (redirect_en) begin
                    pc_d = redir_pc_aligned;
                end else if (pc_stall) begin
                    pc_d    = pc_q;
                    imem_en = 1'b0;
                end
                if (id_flush || redirect_en) begin
                    if_id_d.valid = 1'b0;
                    if_id_d.pc    = pc_q;
                    if_id_d.inst  = NOP_INST;
                end else if (!pc_stall) begin
                    if_id_d.valid = 1'b1;
                    if_id_d.pc    = pc_q;
                    if_id_d.inst  = imem_rdata;
                end
            end
            default: begin
                pc_d          = RESET_PC;
                if_id_d.valid = 1'b0;
                if_id_d.pc    = pc_q;
                if_id_d.inst  = NOP_INST;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            if_id_q.valid <= 1'b0;
            if_id_q.pc    <= RESET_PC;
            if_id_q.inst  <= NOP_INST;
        end else begin
            pc_q    <= pc_d;
            if_id_q <= if_id_d;
        end
    end

    assign imem_addr   = pc_d;
    assign if_id_valid = if_id_q.valid;
    assign if_id_pc    = if_id_q.pc;
    assign if_id_inst  = if_id_q.inst;

`ifdef FETCH_PERF_CNT_EN
    logic run_w;
    logic fetch_ev_w;
    logic stall_ev_w;
    logic flush_ev_w;

    assign run_w      = (state_q == RUN);
    assign flush_ev_w = run_w & (id_flush | redirect_en);
    assign stall_ev_w = run_w & pc_stall & ~redirect_en & ~id_flush;
    assign fetch_ev_w = run_w & ~pc_stall & ~redirect_en & ~id_flush;

    if_perf_cnt u_perf_cnt (
        .clk         (clk),
        .rst         (rst),
        .fetch_ev_i  (fetch_ev_w),
        .stall_ev_i  (stall_ev_w),
        .flush_ev_i  (flush_ev_w),
        .fetch_cnt_o (perf_fetch_cnt),
        .stall_cnt_o (perf_stall_cnt),
        .flush_cnt_o (perf_flush_cnt)
    );
`else
    assign perf_fetch_cnt = 32'h0;
    assign perf_stall_cnt = 32'h0;
    assign perf_flush_cnt = 32'h0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_if_stage.sv
// ============================================================================
// Module   : tb_if_stage
// Brief    : Self-checking bench for if_stage against a fetch-stream model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_if_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        pc_stall;
    logic        id_flush;
    logic        redirect_en;
    logic [31:0] redirect_pc;
    logic        imem_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_inst;
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_flush_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: m_pc is the address whose word the memory presents next
    logic        m_boot;
    logic [31:0] m_pc;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
    logic [31:0] c_fetch, c_stall, c_flush;

    if_stage #(
        .RESET_PC (RESET_PC),
        .NOP_INST (NOP)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .pc_stall       (pc_stall),
        .id_flush       (id_flush),
        .redirect_en    (redirect_en),
        .redirect_pc    (redirect_pc),
        .imem_en        (imem_en),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .if_id_valid    (if_id_valid),
        .if_id_pc       (if_id_pc),
        .if_id_inst     (if_id_inst),
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {2'b00, a[31:2]};
    endfunction

    initial imem_rdata = 32'h0;
    always @(posedge clk) if (imem_en) imem_rdata <= memf(imem_addr);

    function automatic logic [31:0] exp_cnt(input logic [31:0] v);
`ifdef FETCH_PERF_CNT_EN
        return v;
`else
        return (v & 32'h0);
`endif
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_boot  = 1'b1;
        m_pc    = RESET_PC;
        e_valid = 1'b0;
        e_pc    = RESET_PC;
        e_inst  = NOP;
        c_fetch = 32'h0;
        c_stall = 32'h0;
        c_flush = 32'h0;
    endtask

    task automatic check_reset();
        check_val("rst_valid", {31'h0, if_id_valid}, 32'h0);
        check_val("rst_pc",    if_id_pc,   RESET_PC);
        check_val("rst_inst",  if_id_inst, NOP);
        check_val("rst_en",    {31'h0, imem_en}, 32'h1);
        check_val("rst_addr",  imem_addr,  RESET_PC);
        check_val("rst_cf",    perf_fetch_cnt, 32'h0);
        check_val("rst_cs",    perf_stall_cnt, 32'h0);
        check_val("rst_cl",    perf_flush_cnt, 32'h0);
    endtask

    // Called just after a falling edge; returns after the next falling edge.
    task automatic step(input logic st, input logic fl, input logic rd, input logic [31:0] tgt);
        logic        x_en;
        logic [31:0] x_addr;
        logic [31:0] tgt_al;
        pc_stall    = st;
        id_flush    = fl;
        redirect_en = rd;
        redirect_pc = tgt;
        tgt_al      = {tgt[31:2], 2'b00};
        #1;
        if (m_boot) begin
            x_en   = 1'b1;
            x_addr = RESET_PC;
        end else begin
            x_en   = !(st && !rd);
            x_addr = rd ? tgt_al : (st ? m_pc : m_pc + 32'd4);
        end
        check_val("imem_en",   {31'h0, imem_en}, {31'h0, x_en});
        check_val("imem_addr", imem_addr, x_addr);

        if (m_boot) begin
            e_valid = 1'b0; e_pc = m_pc; e_inst = NOP;
            m_pc    = RESET_PC;
            m_boot  = 1'b0;
        end else if (rd || fl) begin
            e_valid = 1'b0; e_pc = m_pc; e_inst = NOP;
            c_flush = c_flush + 32'd1;
            if (rd)       m_pc = tgt_al;
            else if (!st) m_pc = m_pc + 32'd4;
        end else if (st) begin
            c_stall = c_stall + 32'd1;
        end else begin
            e_valid = 1'b1; e_pc = m_pc; e_inst = memf(m_pc);
            c_fetch = c_fetch + 32'd1;
            m_pc    = m_pc + 32'd4;
        end

        @(negedge clk);
        check_val("ifid_valid", {31'h0, if_id_valid}, {31'h0, e_valid});
        check_val("ifid_pc",    if_id_pc,   e_pc);
        check_val("ifid_inst",  if_id_inst, e_inst);
        check_val("cnt_fetch",  perf_fetch_cnt, exp_cnt(c_fetch));
        check_val("cnt_stall",  perf_stall_cnt, exp_cnt(c_stall));
        check_val("cnt_flush",  perf_flush_cnt, exp_cnt(c_flush));
    endtask

    task automatic rand_step();
        step($urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0,
             $urandom_range(0, 9) == 0, $urandom);
    endtask

    initial begin
        rst = 1'b1; pc_stall = 1'b0; id_flush = 1'b0;
        redirect_en = 1'b0; redirect_pc = 32'h0;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset();
        rst = 1'b0;

        // cold start: boot bubble then 0x0, 0x4, 0x8
        step(1'b0, 1'b0, 1'b0, 32'h0);
        repeat (3) step(1'b0, 1'b0, 1'b0, 32'h0);
        // two-cycle stall holding {0x8,2}, then {0xC,3}
        repeat (2) step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        // redirect, then redirect combined with stall
        step(1'b0, 1'b0, 1'b1, 32'h40);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b1, 32'h40);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        // flush plus stall at pc 0x20
        step(1'b0, 1'b0, 1'b1, 32'h20);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        // misaligned target and address wrap
        step(1'b0, 1'b0, 1'b1, 32'h0000_0053);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        repeat (2) step(1'b0, 1'b0, 1'b0, 32'h0);

        repeat (400) rand_step();

        // asynchronous reset between edges
        #3 rst = 1'b1;
        #1 check_reset();
        model_reset();
        repeat (2) @(negedge clk);
        check_reset();
        rst = 1'b0;
        repeat (200) rand_step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
